pdm_decimator: RTL

//   Receive side of the synth's 1-bit delta-sigma DAC stream: converts the PDM bit stream back into
//   16-bit unsigned PCM at the sample rate (20.48 MHz / 512 = 40 kHz). Uses a CIC decimator: ORDER

---
 rtl/synth_pkg.sv | 18 +
 rtl/pdm_decimator_comb.sv | 32 +++
 rtl/pdm_decimator.sv | 118 +++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: rate and width constants shared by the synth audio blocks
// (clkdiv, dac, pdm_decimator), so every block derives the same sample rate.
//   CLK_HZ        system clock frequency
//   SAMPLE_R_LOG2 log2 of clock cycles per PCM sample (512 -> 40 kHz)
//   PCM_W         PCM sample width
//   dec_state_t   pdm_decimator state: WARMUP discards, RUN emits samples
package synth_pkg;

    localparam int unsigned CLK_HZ        = 20_480_000;
    localparam int unsigned SAMPLE_R_LOG2 = 9;
    localparam int unsigned PCM_W         = 16;

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } dec_state_t;

endpackage

// File: rtl/pdm_decimator_comb.sv
// cic_comb: one CIC differentiator stage, y = x - x_delayed (modulo 2**ACC_W).
// The delay register loads x only on capture cycles, so the stage runs at the
// decimated rate while the subtraction itself is combinational.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset (clears the delay register)
//   en   capture enable (one cycle per decimated sample)
//   x    stage input
//   y    stage output
module cic_comb #(
    parameter int unsigned ACC_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] x,
    output logic [ACC_W-1:0] y
);

    logic [ACC_W-1:0] x_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_dly <= '0;
        end else if (en) begin
            x_dly <= x;
        end
    end

    assign y = x - x_dly;

endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator: CIC decimator turning the 1-bit PDM stream back into
// unsigned PCM. ORDER integrators at clock rate, decimation by 2**R_LOG2,
// ORDER combs, then scaling to OUT_W bits with saturation of full scale.
// The first ORDER+1 decimated results are discarded while the filter fills.
// Ports:
//   clk         system clock (same clock as the dac)
//   rst         asynchronous active-high reset
//   din         PDM bit (1 = full-scale contribution)
//   dout        decimated unsigned PCM sample, held between strobes
//   dout_valid  one-cycle strobe when dout is updated
//   settled     high from the first valid sample until reset
module pdm_decimator
    import synth_pkg::*;
#(
    parameter int unsigned ORDER  = 3,
    parameter int unsigned R_LOG2 = SAMPLE_R_LOG2,
    parameter int unsigned OUT_W  = PCM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             settled
);

    localparam int unsigned ACC_W  = ORDER * R_LOG2 + 1;
    localparam int unsigned SHIFT  = ACC_W - 1 - OUT_W;
    localparam int unsigned DISC_W = $clog2(ORDER + 2);
    localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(ORDER + 1);

    logic [ACC_W-1:0]          integ [ORDER];
    logic [ACC_W-1:0]          din_ext;
    logic [R_LOG2-1:0]         dec_cnt;
    logic                      capture;
    logic [ORDER:0][ACC_W-1:0] comb_io;
    logic [OUT_W:0]            y_scaled;
    logic [OUT_W-1:0]          y_sat;
    dec_state_t                state;
    logic [DISC_W-1:0]         disc_cnt;

    assign din_ext = {{(ACC_W-1){1'b0}}, din};

    // Integrator chain; wrap-around is intended, the combs undo it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
            end
        end else begin
            integ[0] <= integ[0] + din_ext;
            for (int unsigned k = 1; k < ORDER; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

    assign capture = (dec_cnt == '1);

    assign comb_io[0] = integ[ORDER-1];

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb #(
            .ACC_W(ACC_W)
        ) u_comb (
            .clk (clk),
            .rst (rst),
            .en  (capture),
            .x   (comb_io[g]),
            .y   (comb_io[g+1])
        );
    end

    // DC full scale gives exactly 2**(ACC_W-1); after the shift only that
    // case sets the top bit, and it is clamped to all-ones.
    assign y_scaled = comb_io[ORDER][ACC_W-1:SHIFT];
    assign y_sat    = y_scaled[OUT_W] ? '1 : y_scaled[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WARMUP;
            disc_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            settled    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (capture) begin
                case (state)
                    WARMUP: begin
                        if (disc_cnt == DISC_LAST) begin
                            state      <= RUN;
                            settled    <= 1'b1;
                            dout       <= y_sat;
                            dout_valid <= 1'b1;
                        end else begin
                            disc_cnt <= disc_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        dout       <= y_sat;
                        dout_valid <= 1'b1;
                    end
                    default: state <= WARMUP;
                endcase
            end
        end
    end

endmodule
